pattern_bit_transmitter: RTL

Serial pattern generator. It is the transmit-side counterpart to the team's serial sequence detectors: it loads a PATTERN_W-bit word over a valid/ready handshake and emits it MSB-first, one bit per clock, on out_bit. The pattern repeats a programmable number of times, with an optional run of idle gap cycles between repetitions. Used as a stimulus source for bit-stream receivers on the FPGA boards and in benches.

---
 rtl/pattern_bit_transmitter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pattern_bit_transmitter.sv
// Serial pattern source: loads a word over valid/ready and shifts it out MSB-first,
// repeating a programmable number of times with GAP_LEN idle cycles between repetitions.
module pattern_bit_transmitter #(
  parameter int PATTERN_W = 4,
  parameter int REP_W     = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PATTERN_W-1:0] pattern_in,
  input  logic [REP_W-1:0]     rep_in,
  input  logic                 abort,
  output logic                 out_bit,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(PATTERN_W);
  localparam int GAP_W = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PATTERN_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = (GAP_LEN > 0) ? GAP_W'(GAP_LEN - 1) : '0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t               state, state_nx;
  logic [PATTERN_W-1:0] pat, pat_nx;
  logic [PATTERN_W-1:0] shreg, shreg_nx;
  logic [REP_W-1:0]     reps, reps_nx;
  logic [CNT_W-1:0]     bitcnt, bitcnt_nx;
  logic [GAP_W-1:0]     gapcnt, gapcnt_nx;
  logic                 out_bit_nx, out_valid_nx, busy_nx, done_nx;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pat       <= '0;
      shreg     <= '0;
      reps      <= '0;
      bitcnt    <= '0;
      gapcnt    <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      pat       <= pat_nx;
      shreg     <= shreg_nx;
      reps      <= reps_nx;
      bitcnt    <= bitcnt_nx;
      gapcnt    <= gapcnt_nx;
      out_bit   <= out_bit_nx;
      out_valid <= out_valid_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  // Outputs are computed one cycle ahead so every output leaves a flop.
  // shreg holds the bits still to be sent after the one currently on out_bit.
  always_comb begin
    state_nx     = state;
    pat_nx       = pat;
    shreg_nx     = shreg;
    reps_nx      = reps;
    bitcnt_nx    = bitcnt;
    gapcnt_nx    = gapcnt;
    out_bit_nx   = 1'b0;
    out_valid_nx = 1'b0;
    busy_nx      = 1'b1;
    done_nx      = 1'b0;
    case (state)
      IDLE: begin
        busy_nx = 1'b0;
        if (in_valid) begin
          state_nx     = SHIFT;
          pat_nx       = pattern_in;
          shreg_nx     = pattern_in << 1;
          reps_nx      = (rep_in == '0) ? REP_W'(1) : rep_in;
          bitcnt_nx    = '0;
          gapcnt_nx    = '0;
          out_bit_nx   = pattern_in[PATTERN_W-1];
          out_valid_nx = 1'b1;
          busy_nx      = 1'b1;
        end
      end
      SHIFT: begin
        if (bitcnt == LAST_BIT) begin
          bitcnt_nx = '0;
          if (reps != REP_W'(1)) begin
            reps_nx = reps - 1'b1;
            if (GAP_LEN > 0) begin
              state_nx  = GAP;
              gapcnt_nx = '0;
            end else begin
              shreg_nx     = pat << 1;
              out_bit_nx   = pat[PATTERN_W-1];
              out_valid_nx = 1'b1;
            end
          end else begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end
        end else begin
          bitcnt_nx    = bitcnt + 1'b1;
          shreg_nx     = shreg << 1;
          out_bit_nx   = shreg[PATTERN_W-1];
          out_valid_nx = 1'b1;
        end
      end
      GAP: begin
        if (gapcnt == LAST_GAP) begin
          state_nx     = SHIFT;
          shreg_nx     = pat << 1;
          out_bit_nx   = pat[PATTERN_W-1];
          out_valid_nx = 1'b1;
        end else begin
          gapcnt_nx = gapcnt + 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
    // Abort wins over any in-flight transition; the next load reinitialises all counters.
    if (abort && (state != IDLE)) begin
      state_nx     = IDLE;
      out_bit_nx   = 1'b0;
      out_valid_nx = 1'b0;
      busy_nx      = 1'b0;
      done_nx      = 1'b0;
    end
  end

endmodule
